fetch_queue: RTL and testbench

- Instruction buffer between the fetch stage (PC / add4 / instruction memory) and decode/control.
- Decouples fetch from decode with a valid/ready handshake on each side.
- Holds up to DEPTH {pc, inst} pairs.
- Flags jump opcodes at the head for the control stage.
- Supports a one-cycle flush on redirect.
- Raises a sticky halt when the all-zero end-of-program word is enqueued.

---
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, inst} pairs between fetch and decode,
// flags j/jal at the head, flushes on redirect and latches halt on the zero word.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_is_jump,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             halt
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             halt_q, halt_d;
  logic             push, pop, wr_en;
  logic [63:0]      head;
  logic [5:0]       head_op;

  assign in_ready  = (count_q != FULL_CNT) && !halt_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Flush or reset in the same cycle cancels the storage write.
  assign wr_en     = push && !flush && resetn;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halt_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (in_inst == 32'h0000_0000) halt_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_pc, in_inst};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    head_op     = head[31:26];
    out_pc      = out_valid ? head[63:32] : 32'h0;
    out_inst    = out_valid ? head[31:0]  : 32'h0;
    out_is_jump = out_valid && ((head_op == 6'h02) || (head_op == 6'h03));
  end

  assign count = count_q;
  assign halt  = halt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue of expected {pc, inst}
// entries is checked against the head and status outputs every cycle.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        resetn, in_valid, in_ready, out_valid, out_ready;
  logic        out_is_jump, flush, halt;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  logic        m_halt = 1'b0;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_is_jump(out_is_jump), .flush(flush),
    .count(count), .halt(halt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all outputs mid-cycle, then advance the model across the next edge.
  task automatic cycle();
    logic        exp_ready, do_push, do_pop;
    logic [63:0] hd, dropped;
    @(negedge clock);
    exp_ready = (sb.size() != 4) && !m_halt;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("count", 64'(count), 64'(sb.size()));
    chk("halt", 64'(halt), 64'(m_halt));
    if (sb.size() != 0) begin
      hd = sb[0];
      chk("out_pc", 64'(out_pc), 64'(hd[63:32]));
      chk("out_inst", 64'(out_inst), 64'(hd[31:0]));
      chk("out_is_jump", 64'(out_is_jump),
          64'((hd[31:26] == 6'h02) || (hd[31:26] == 6'h03)));
    end else begin
      chk("out_pc_empty", 64'(out_pc), 64'h0);
      chk("out_inst_empty", 64'(out_inst), 64'h0);
      chk("out_is_jump_empty", 64'(out_is_jump), 64'h0);
    end
    do_push = in_valid && exp_ready;
    do_pop  = (sb.size() != 0) && out_ready;
    if (!resetn || flush) begin
      sb.delete();
      m_halt = 1'b0;
    end else begin
      if (do_pop) dropped = sb.pop_front();
      if (do_push) begin
        sb.push_back({in_pc, in_inst});
        if (in_inst == 32'h0) m_halt = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    cycle();
    resetn = 1'b1;

    // Fill to full; fifth push must be ignored.
    for (int i = 0; i < 5; i++)
      begin drive(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2008_0001 + 32'(i), 1'b0); cycle(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 32'h0, 32'h0, 1'b1); cycle(); end

    // Streaming with simultaneous push/pop; pointers wrap.
    for (int i = 0; i < 10; i++)
      begin drive(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2008_0010 + 32'(i), 1'b1); cycle(); end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 32'h0, 32'h0, 1'b1); cycle(); end

    // Jump flags at the head.
    drive(1'b1, 32'h0040_0000, 32'h0810_0002, 1'b0); cycle();
    drive(1'b1, 32'h0040_0004, 32'h0C10_0003, 1'b0); cycle();
    drive(1'b1, 32'h0040_0008, 32'h2008_0005, 1'b0); cycle();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 32'h0, 32'h0, 1'b1); cycle(); end

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++)
      begin drive(1'b1, 32'h0040_0010 + 32'(4*i), 32'h2008_0020 + 32'(i), 1'b0); cycle(); end
    flush = 1'b1;
    drive(1'b1, 32'h0040_0020, 32'h2008_0030, 1'b1); cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1); cycle();
    cycle();

    // Halt on the zero word; blocked pushes; drain; flush clears halt.
    drive(1'b1, 32'h0040_0000, 32'h2008_0001, 1'b0); cycle();
    drive(1'b1, 32'h0040_0004, 32'h0000_0000, 1'b0); cycle();
    drive(1'b1, 32'h0040_0008, 32'h2008_0009, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h0040_0008, 32'h2008_0009, 1'b1); cycle(); end
    flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0); cycle();
    flush = 1'b0;
    cycle();

    // Reset mid-operation with a push and pop in the same cycle.
    drive(1'b1, 32'h0040_0040, 32'h2008_0041, 1'b0); cycle();
    drive(1'b1, 32'h0040_0044, 32'h2008_0042, 1'b0); cycle();
    resetn = 1'b0;
    drive(1'b1, 32'h0040_0048, 32'h2008_0043, 1'b1); cycle();
    resetn = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0); cycle();
    drive(1'b1, 32'h0040_0050, 32'h2008_0050, 1'b1); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1); cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
